// File: rtl/fetch_ctrl.sv
// Fetch controller: sequences the fetch PC against a handshaked instruction memory,
// with a single-entry output slot, branch redirects and a memory-timeout trap.
// Optional misaligned-redirect trap enabled by defining FETCH_CTRL_MISALIGN_TRAP_EN.
module fetch_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_base,
    input  logic [XLEN-1:0] redirect_imm,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] pc,
    output logic            timeout_err,
    output logic            misalign_err
);

    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, FETCH, ERR} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic [31:0]     instr_q, instr_d;
    logic            valid_q, valid_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            terr_q, terr_d;
    logic [XLEN-1:0] target;
    logic            ack_fire;
    logic            consume;

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    logic            merr_q, merr_d;
`endif

    // Request is withheld while the slot is blocked or a redirect is squashing this cycle.
    assign imem_req  = (state_q == FETCH) && !(valid_q && stall) && !redirect_valid;
    assign imem_addr = pc_q;
    assign target    = redirect_base + redirect_imm;
    assign ack_fire  = imem_req && imem_ack;
    assign consume   = valid_q && !stall;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;
        terr_d     = terr_q;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
        merr_d     = merr_q;
`endif
        if (state_q != ERR && redirect_valid) begin
            valid_d = 1'b0;
            cnt_d   = '0;
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
            if (target[1:0] != 2'b00) begin
                merr_d  = 1'b1;
                state_d = ERR;
            end else begin
                pc_d    = target;
                state_d = FETCH;
            end
`else
            pc_d    = target & ~XLEN'(3);
            state_d = FETCH;
`endif
        end else begin
            case (state_q)
                IDLE: state_d = FETCH;
                FETCH: begin
                    if (cnt_q == CNT_MAX) begin
                        state_d = ERR;
                        terr_d  = 1'b1;
                        valid_d = 1'b0;
                    end else if (ack_fire) begin
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                        pc_d       = pc_q + XLEN'(4);
                        cnt_d      = '0;
                    end else begin
                        if (consume) valid_d = 1'b0;
                        // Only consecutive unacknowledged request cycles count toward timeout.
                        cnt_d = imem_req ? cnt_q + CW'(1) : '0;
                    end
                end
                default: valid_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
            terr_q     <= terr_d;
        end
    end

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) merr_q <= 1'b0;
        else      merr_q <= merr_d;
    end
    assign misalign_err = merr_q;
`else
    assign misalign_err = 1'b0;
`endif

    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: table-driven vectors with a post-edge
// expectation queue, plus hand-written timeout / ERR / async-reset sequences.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_base;
    logic [31:0] redirect_imm;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc;
    logic        timeout_err;
    logic        misalign_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic [31:0] pc;
        logic        merr;
    } exp_t;

    typedef struct {
        logic        rv;
        logic [31:0] base;
        logic [31:0] imm;
        logic        st;
        logic        ack;
        logic [31:0] rdata;
        logic        exp_req;
        logic [31:0] exp_addr;
        exp_t        post;
    } vec_t;

    exp_t scoreboard[$];
    vec_t vecs[$];

    fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0), .TIMEOUT(15)) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_base (redirect_base),
        .redirect_imm  (redirect_imm),
        .stall         (stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .pc            (pc),
        .timeout_err   (timeout_err),
        .misalign_err  (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rv, input logic [31:0] base, input logic [31:0] imm,
                                input logic st, input logic ack, input logic [31:0] rdata,
                                input logic ereq, input logic [31:0] eaddr,
                                input logic ev, input logic [31:0] ei, input logic [31:0] eipc,
                                input logic [31:0] epc, input logic em);
        vec_t v;
        v.rv = rv; v.base = base; v.imm = imm; v.st = st; v.ack = ack; v.rdata = rdata;
        v.exp_req = ereq; v.exp_addr = eaddr;
        v.post.valid = ev; v.post.instr = ei; v.post.ipc = eipc; v.post.pc = epc; v.post.merr = em;
        return v;
    endfunction

    task automatic checkOutput(input int idx);
        exp_t e;
        string tag;
        if (scoreboard.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_empty row=%0d", idx);
            return;
        end
        e = scoreboard.pop_front();
        tag = $sformatf("row%0d", idx);
        check_val({tag, "_valid"}, 32'(instr_valid), 32'(e.valid));
        check_val({tag, "_instr"}, instr, e.instr);
        check_val({tag, "_instr_pc"}, instr_pc, e.ipc);
        check_val({tag, "_pc"}, pc, e.pc);
        check_val({tag, "_addr_eq_pc"}, imem_addr, e.pc);
        check_val({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        check_val({tag, "_misalign_err"}, 32'(misalign_err), 32'(e.merr));
    endtask

    // Drives one cycle's inputs, checks the combinational request, queues the post-edge expectation.
    task automatic applyStimulus(input vec_t v, input int idx);
        redirect_valid = v.rv;
        redirect_base  = v.base;
        redirect_imm   = v.imm;
        stall          = v.st;
        imem_ack       = v.ack;
        imem_rdata     = v.rdata;
        #1;
        check_val($sformatf("row%0d_req", idx), 32'(imem_req), 32'(v.exp_req));
        check_val($sformatf("row%0d_addr_pre", idx), imem_addr, v.exp_addr);
        scoreboard.push_back(v.post);
        @(posedge clk);
        #1;
        checkOutput(idx);
    endtask

    initial begin
        rst = 1'b0;
        redirect_valid = 1'b0;
        redirect_base = '0;
        redirect_imm = '0;
        stall = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = '0;

        //    rv base          imm           st ack rdata         req addr          v  instr         ipc           pc            merr
        vecs.push_back(mk(0, 32'h0,        32'h0,        0, 1, 32'h0000_0011, 0, 32'h0,        0, 32'h0,        32'h0, 32'h0,   0));
        vecs.push_back(mk(0, 32'h0,        32'h0,        0, 1, 32'hA000_0000, 1, 32'h0,        1, 32'hA000_0000, 32'h0, 32'h4,   0));
        vecs.push_back(mk(0, 32'h0,        32'h0,        0, 1, 32'hA000_0004, 1, 32'h4,        1, 32'hA000_0004, 32'h4, 32'h8,   0));
        vecs.push_back(mk(0, 32'h0,        32'h0,        0, 1, 32'hA000_0008, 1, 32'h8,        1, 32'hA000_0008, 32'h8, 32'hC,   0));
        vecs.push_back(mk(0, 32'h0,        32'h0,        1, 1, 32'hDEAD_BEEF, 0, 32'hC,        1, 32'hA000_0008, 32'h8, 32'hC,   0));
        vecs.push_back(mk(0, 32'h0,        32'h0,        1, 1, 32'hDEAD_BEEF, 0, 32'hC,        1, 32'hA000_0008, 32'h8, 32'hC,   0));
        vecs.push_back(mk(0, 32'h0,        32'h0,        1, 1, 32'hDEAD_BEEF, 0, 32'hC,        1, 32'hA000_0008, 32'h8, 32'hC,   0));
        vecs.push_back(mk(0, 32'h0,        32'h0,        0, 1, 32'hA000_000C, 1, 32'hC,        1, 32'hA000_000C, 32'hC, 32'h10,  0));
        vecs.push_back(mk(1, 32'h8,        32'hFFFF_FFF8, 0, 1, 32'hDEAD_BEEF, 0, 32'h10,       0, 32'hA000_000C, 32'hC, 32'h0,   0));
        vecs.push_back(mk(0, 32'h0,        32'h0,        0, 0, 32'h0,        1, 32'h0,        0, 32'hA000_000C, 32'hC, 32'h0,   0));
        vecs.push_back(mk(0, 32'h0,        32'h0,        0, 1, 32'hB000_0000, 1, 32'h0,        1, 32'hB000_0000, 32'h0, 32'h4,   0));
        vecs.push_back(mk(0, 32'h0,        32'h0,        0, 1, 32'hB000_0004, 1, 32'h4,        1, 32'hB000_0004, 32'h4, 32'h8,   0));
        vecs.push_back(mk(0, 32'h0,        32'h0,        0, 0, 32'h0,        1, 32'h8,        0, 32'hB000_0004, 32'h4, 32'h8,   0));
        vecs.push_back(mk(1, 32'hFFFF_FFFC, 32'h8,       0, 0, 32'h0,        0, 32'h8,        0, 32'hB000_0004, 32'h4, 32'h4,   0));
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
        vecs.push_back(mk(1, 32'h100,      32'h2,        0, 0, 32'h0,        0, 32'h4,        0, 32'hB000_0004, 32'h4, 32'h4,   1));
        vecs.push_back(mk(0, 32'h0,        32'h0,        0, 1, 32'hC000_0000, 0, 32'h4,        0, 32'hB000_0004, 32'h4, 32'h4,   1));
`else
        vecs.push_back(mk(1, 32'h100,      32'h2,        0, 0, 32'h0,        0, 32'h4,        0, 32'hB000_0004, 32'h4, 32'h100, 0));
        vecs.push_back(mk(0, 32'h0,        32'h0,        0, 1, 32'hC000_0000, 1, 32'h100,      1, 32'hC000_0000, 32'h100, 32'h104, 0));
`endif

        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_val("reset_pc", pc, 32'h0);
        check_val("reset_valid", 32'(instr_valid), 32'd0);
        check_val("reset_req", 32'(imem_req), 32'd0);
        check_val("reset_instr", instr, 32'h0);
        check_val("reset_terr", 32'(timeout_err), 32'd0);
        check_val("reset_merr", 32'(misalign_err), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

        // Asynchronous reset with no clock edge clears the slot and PC.
        rst = 1'b0;
        #1;
        check_val("async_rst1_pc", pc, 32'h0);
        check_val("async_rst1_instr_pc", instr_pc, 32'h0);
        check_val("async_rst1_merr", 32'(misalign_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        redirect_valid = 1'b0;
        stall = 1'b0;
        imem_ack = 1'b0;
        @(posedge clk);
        #1;
        imem_ack = 1'b1;
        imem_rdata = 32'hD000_0000;
        @(posedge clk);
        #1;
        imem_rdata = 32'hD000_0004;
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        check_val("to_pre_pc", pc, 32'h8);
        check_val("to_pre_instr", instr, 32'hD000_0004);

        // Fifteen unacknowledged request cycles must not trap yet.
        for (int i = 0; i < 15; i++) begin
            #1;
            check_val($sformatf("to_req_%0d", i), 32'(imem_req), 32'd1);
            @(posedge clk);
            #1;
        end
        check_val("to_terr_before", 32'(timeout_err), 32'd0);
        check_val("to_valid_consumed", 32'(instr_valid), 32'd0);
        @(posedge clk);
        #1;
        check_val("to_terr_after", 32'(timeout_err), 32'd1);
        check_val("to_req_after", 32'(imem_req), 32'd0);
        check_val("to_pc_frozen", pc, 32'h8);

        redirect_valid = 1'b1;
        redirect_base = 32'h40;
        redirect_imm = 32'h0;
        #1;
        check_val("err_redir_req", 32'(imem_req), 32'd0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        check_val("err_redir_pc", pc, 32'h8);
        check_val("err_redir_terr", 32'(timeout_err), 32'd1);
        check_val("err_redir_valid", 32'(instr_valid), 32'd0);

        #2;
        rst = 1'b0;
        #1;
        check_val("err_rst_pc", pc, 32'h0);
        check_val("err_rst_instr", instr, 32'h0);
        check_val("err_rst_instr_pc", instr_pc, 32'h0);
        check_val("err_rst_terr", 32'(timeout_err), 32'd0);
        check_val("err_rst_valid", 32'(instr_valid), 32'd0);
        check_val("err_rst_req", 32'(imem_req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the program counter against a handshaked instruction memory.
- Holds the fetch PC, issues one outstanding request at a time, and registers returned instructions into a single-entry output slot with downstream back-pressure.
- Applies branch redirects (PC-relative target), flushes stale fetches, and traps on memory timeout.
- Sits between the PC/next-PC datapath and decode, replacing a free-running PC update.

Parameters:
XLEN, 32, width of PC and addresses
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 15, max consecutive request cycles without ack before error; counter width $clog2(TIMEOUT+1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted when 0)
redirect_valid  in  1  taken branch/jump this cycle
redirect_base  in  XLEN  PC of the branching instruction
redirect_imm  in  XLEN  sign-extended immediate offset
stall  in  1  downstream cannot accept instr this cycle
imem_req  out  1  fetch request
imem_addr  out  XLEN  fetch address, equals pc
imem_ack  in  1  response valid; meaningful only when imem_req=1
imem_rdata  in  32  returned instruction word
instr_valid  out  1  output slot holds a valid instruction
instr  out  32  registered instruction
instr_pc  out  XLEN  address instr was fetched from
pc  out  XLEN  current fetch PC
timeout_err  out  1  sticky memory-timeout flag
misalign_err  out  1  sticky misaligned-redirect flag (see Optional Feature)

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, pc=RESET_PC, instr_valid=0, instr=0, instr_pc=0, counter=0, both error flags 0.
  - imem_req=0 while in IDLE.
- States: IDLE, FETCH, ERR.
  - IDLE -> FETCH on the first clock edge after rst deasserts.
  - FETCH -> ERR on timeout or misalign trap.
  - ERR is absorbing until reset.
- imem_req = (state==FETCH) && !(instr_valid && stall) && !redirect_valid. This is combinational. imem_addr=pc at all times.
- Consume: the slot instruction is consumed in any cycle where instr_valid=1 and stall=0. If no new ack arrives that cycle, instr_valid clears on the next edge.
- Ack (imem_req=1 && imem_ack=1 at edge n):
  - On edge n: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4 (mod 2^XLEN), counter<=0.
  - Latency: ack at edge n means instr_valid is visible from n to n+1.
  - Back-to-back acks give one instruction per cycle.
- imem_ack while imem_req=0 is ignored.
- Dropping imem_req before ack cancels the request; the memory must tolerate this.
- Timeout:
  - Each FETCH cycle with imem_req=1 and imem_ack=0 increments counter.
  - Counter clears on ack, redirect, or a cycle with imem_req=0.
  - When counter reaches TIMEOUT, the next edge enters ERR and sets timeout_err=1.
- Redirect (redirect_valid=1 at edge, state != ERR):
  - pc<=redirect_base+redirect_imm, with wrap-around and carry discarded.
  - instr_valid<=0 (flush), counter<=0, state<=FETCH (also from IDLE).
  - Priority: redirect > ack > consume. An ack in the same cycle cannot occur because imem_req is forced 0.
- ERR: imem_req=0, instr_valid=0, pc frozen, redirects ignored.
- Reset mid-request: all state returns to reset values immediately. No pending request survives.

Optional Feature:
- Macro: FETCH_CTRL_MISALIGN_TRAP_EN.
- Defined:
  - A redirect whose target[1:0] != 0 does not update pc.
  - It sets misalign_err=1 and instr_valid<=0, and the next state is ERR.
- Undefined:
  - target[1:0] is forced to 2'b00 before loading pc.
  - misalign_err is tied 0.

Test Plan:
- Reset release, imem_ack=1 every cycle, stall=0 -> imem_addr 0x0,0x4,0x8 on successive cycles; instr_pc follows one cycle behind; instr_valid=1 continuously from the 2nd edge after release.
- Ack at pc=0x8, then stall=1 for 3 cycles -> instr and instr_pc=0x8 stable; imem_req=0 during the stall; fetch of 0xC resumes the cycle stall drops.
- At pc=0x10, redirect_base=0x8, redirect_imm=0xFFFF_FFF8 (-8) -> pc=0x0 next edge; instr_valid=0 for that cycle; next request addr 0x0.
- redirect_base=0xFFFF_FFFC, imm=0x8 -> pc wraps to 0x4.
- imem_ack held 0 with TIMEOUT=15 -> after 15 unacked request cycles, the next edge gives timeout_err=1 and imem_req=0; a later redirect is ignored; rst=0 mid-ERR clears all outputs asynchronously.
- Redirect target 0x102 -> with the macro: misalign_err=1, ERR, pc unchanged; without it: pc=0x100 and fetch continues.
